// File: rtl/game_setup_pkg.sv
// Shared types and constants for the game-setup sequencer: FSM states,
// configuration bus width and the per-level parameter table.
package game_setup_pkg;

  localparam int CFG_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LD_SIZE,
    ST_LD_MINES,
    ST_LD_TIME,
    ST_GEN_WAIT,
    ST_READY
  } setup_state_t;

  typedef struct packed {
    logic [CFG_W-1:0] size;
    logic [CFG_W-1:0] mines;
    logic [CFG_W-1:0] secs;
  } level_cfg_t;

  localparam level_cfg_t EASY_CFG   = '{size: 10'd8,  mines: 10'd10, secs: 10'd300};
  localparam level_cfg_t MEDIUM_CFG = '{size: 10'd16, mines: 10'd40, secs: 10'd600};
  localparam level_cfg_t HARD_CFG   = '{size: 10'd24, mines: 10'd99, secs: 10'd900};

  // Levels outside the table read as all-zero so an oversized LEVELS is harmless.
  function automatic level_cfg_t level_params(input logic [1:0] level);
    level_cfg_t cfg;
    cfg = '0;
    case (level)
      2'd0:    cfg = EASY_CFG;
      2'd1:    cfg = MEDIUM_CFG;
      2'd2:    cfg = HARD_CFG;
      default: cfg = '0;
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/game_setup_ctrl_level_sel_cnt.sv
// Saturating up/down level counter for the difficulty menu; counts only
// while enabled, and simultaneous up/down cancel out.
module level_sel_cnt #(
  parameter int LEVELS = 3,
  parameter int W      = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] level
);

  localparam logic [W-1:0] MAX_LVL = W'(LEVELS - 1);

  logic [W-1:0] level_q;
  logic [W-1:0] level_d;

  always_comb begin
    level_d = level_q;
    if (enable && (up != down)) begin
      if (up && (level_q != MAX_LVL)) begin
        level_d = level_q + 1'b1;
      end else if (down && (level_q != '0)) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/game_setup_ctrl.sv
// Game-setup sequencer: level selection, three-step parameter load over a
// shared bus, mine-generator handshake with timeout, then hold setup_done.
module game_setup_ctrl #(
  parameter int LEVELS      = 3,
  parameter int CFG_W       = game_setup_pkg::CFG_W,
  parameter int GEN_TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_setup,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_confirm,
  input  logic             game_over,
  input  logic             gen_ack,
  output logic [1:0]       level_sel,
  output logic [CFG_W-1:0] cfg_data,
  output logic [2:0]       latch_en,
  output logic             gen_req,
  output logic             gen_err,
  output logic             setup_done,
  output logic             busy
);

  import game_setup_pkg::*;

  localparam int               CNT_W    = $clog2(GEN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(GEN_TIMEOUT - 1);

  setup_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] cfg_data_q, cfg_data_d;
  logic [2:0]       latch_en_q, latch_en_d;
  logic             gen_req_q, gen_req_d;
  logic             gen_err_q, gen_err_d;
  logic             setup_done_q, setup_done_d;
  logic             busy_q, busy_d;
  level_cfg_t       lvl_cfg;
  logic             sel_enable;

  // Confirm freezes the level so the load uses the value shown before the press.
  assign sel_enable = (state_q == ST_SELECT) && !btn_confirm && !game_over;

  level_sel_cnt #(
    .LEVELS(LEVELS),
    .W     (2)
  ) u_level_sel_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(sel_enable),
    .up    (btn_up),
    .down  (btn_down),
    .level (level_sel)
  );

  assign lvl_cfg = level_params(level_sel);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statements can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gen_err_d = 1'b0;

    case (state_q)
      ST_IDLE:     if (start_setup) state_d = ST_SELECT;
      ST_SELECT:   if (btn_confirm) state_d = ST_LD_SIZE;
      ST_LD_SIZE:  state_d = ST_LD_MINES;
      ST_LD_MINES: state_d = ST_LD_TIME;
      ST_LD_TIME: begin
        state_d = ST_GEN_WAIT;
        cnt_d   = '0;
      end
      ST_GEN_WAIT: begin
        if (gen_ack) begin
          state_d = ST_READY;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = ST_SELECT;
          gen_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_READY:    if (start_setup) state_d = ST_SELECT;
      default:     state_d = ST_IDLE;
    endcase

    if (game_over) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      gen_err_d = 1'b0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    latch_en_d   = 3'b000;
    cfg_data_d   = '0;
    case (state_d)
      ST_LD_SIZE: begin
        latch_en_d = 3'b001;
        cfg_data_d = CFG_W'(lvl_cfg.size);
      end
      ST_LD_MINES: begin
        latch_en_d = 3'b010;
        cfg_data_d = CFG_W'(lvl_cfg.mines);
      end
      ST_LD_TIME: begin
        latch_en_d = 3'b100;
        cfg_data_d = CFG_W'(lvl_cfg.secs);
      end
      default: ;
    endcase
    gen_req_d    = (state_d == ST_GEN_WAIT);
    setup_done_d = (state_d == ST_READY);
    busy_d       = (state_d != ST_IDLE) && (state_d != ST_READY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      cfg_data_q   <= '0;
      latch_en_q   <= 3'b000;
      gen_req_q    <= 1'b0;
      gen_err_q    <= 1'b0;
      setup_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_data_q   <= cfg_data_d;
      latch_en_q   <= latch_en_d;
      gen_req_q    <= gen_req_d;
      gen_err_q    <= gen_err_d;
      setup_done_q <= setup_done_d;
      busy_q       <= busy_d;
    end
  end

  assign cfg_data   = cfg_data_q;
  assign latch_en   = latch_en_q;
  assign gen_req    = gen_req_q;
  assign gen_err    = gen_err_q;
  assign setup_done = setup_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_game_setup_ctrl.sv
// Scoreboard bench for game_setup_ctrl: expectations are queued when stimulus
// is driven and compared one cycle later, just after the clock edge.
module tb_game_setup_ctrl;

  localparam int CFG_W = 10;
  localparam int SIG_LEVEL = 0, SIG_CFG = 1, SIG_LATCH = 2, SIG_REQ = 3,
                 SIG_ERR = 4, SIG_DONE = 5, SIG_BUSY = 6;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_setup, btn_up, btn_down, btn_confirm, game_over, gen_ack;
  logic [1:0]       level_sel;
  logic [CFG_W-1:0] cfg_data;
  logic [2:0]       latch_en;
  logic             gen_req, gen_err, setup_done, busy;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  game_setup_ctrl #(
    .LEVELS     (3),
    .CFG_W      (CFG_W),
    .GEN_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_setup(start_setup),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_confirm(btn_confirm),
    .game_over  (game_over),
    .gen_ack    (gen_ack),
    .level_sel  (level_sel),
    .cfg_data   (cfg_data),
    .latch_en   (latch_en),
    .gen_req    (gen_req),
    .gen_err    (gen_err),
    .setup_done (setup_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_LEVEL: return 32'(level_sel);
      SIG_CFG:   return 32'(cfg_data);
      SIG_LATCH: return 32'(latch_en);
      SIG_REQ:   return 32'(gen_req);
      SIG_ERR:   return 32'(gen_err);
      SIG_DONE:  return 32'(setup_done);
      SIG_BUSY:  return 32'(busy);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_next(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Expectations for a load cycle: strobe, bus value, and busy.
  task automatic expect_load(input string tag, input logic [2:0] le, input int val);
    expect_next({tag, "_latch"}, SIG_LATCH, 32'(le));
    expect_next({tag, "_cfg"},   SIG_CFG,   32'(val));
    expect_next({tag, "_busy"},  SIG_BUSY,  32'd1);
    expect_next({tag, "_req"},   SIG_REQ,   32'd0);
  endtask

  // Advance one clock, compare everything queued, then drop pulse inputs.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.tag, observe(e.sig), e.val);
    end
    start_setup = 1'b0;
    btn_up      = 1'b0;
    btn_down    = 1'b0;
    btn_confirm = 1'b0;
    game_over   = 1'b0;
    gen_ack     = 1'b0;
  endtask

  // Confirm at the current level and walk through the three load cycles.
  task automatic confirm_and_load(input string tag, input int sz, input int mn, input int tm);
    btn_confirm = 1'b1;
    expect_load({tag, "_size"}, 3'b001, sz);
    step();
    expect_load({tag, "_mines"}, 3'b010, mn);
    step();
    expect_load({tag, "_time"}, 3'b100, tm);
    step();
    expect_next({tag, "_req_rise"}, SIG_REQ, 32'd1);
    expect_next({tag, "_latch_off"}, SIG_LATCH, 32'd0);
    expect_next({tag, "_cfg_off"}, SIG_CFG, 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {start_setup, btn_up, btn_down, btn_confirm, game_over, gen_ack} = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", 32'(level_sel), 32'd0);
    check("rst_cfg", 32'(cfg_data), 32'd0);
    check("rst_latch", 32'(latch_en), 32'd0);
    check("rst_flags", 32'({gen_req, gen_err, setup_done, busy}), 32'd0);
    rst_n = 1'b1;

    // Idle ignores buttons; start opens selection.
    btn_up = 1'b1;
    expect_next("idle_up_ignored", SIG_LEVEL, 32'd0);
    expect_next("idle_busy", SIG_BUSY, 32'd0);
    step();
    start_setup = 1'b1;
    expect_next("select_busy", SIG_BUSY, 32'd1);
    step();

    btn_down = 1'b1;
    expect_next("down_sat_zero", SIG_LEVEL, 32'd0);
    step();
    btn_up = 1'b1;
    expect_next("up_to_1", SIG_LEVEL, 32'd1);
    step();
    btn_up = 1'b1; btn_down = 1'b1;
    expect_next("up_down_hold", SIG_LEVEL, 32'd1);
    step();
    btn_up = 1'b1;
    expect_next("up_to_2", SIG_LEVEL, 32'd2);
    step();
    btn_up = 1'b1;
    expect_next("up_sat_top", SIG_LEVEL, 32'd2);
    step();

    // Confirm wins over a concurrent down press; hard level loads.
    btn_down = 1'b1;
    confirm_and_load("hard", 24, 99, 900);
    check("hard_level_kept", 32'(level_sel), 32'd2);

    // Ack on the fifth GEN_WAIT cycle.
    for (int i = 1; i <= 4; i++) begin
      expect_next("wait_req", SIG_REQ, 32'd1);
      step();
    end
    gen_ack = 1'b1;
    expect_next("ack_req_drop", SIG_REQ, 32'd0);
    expect_next("ack_done", SIG_DONE, 32'd1);
    expect_next("ack_busy", SIG_BUSY, 32'd0);
    step();
    gen_ack = 1'b1;
    expect_next("ready_hold", SIG_DONE, 32'd1);
    step();
    game_over = 1'b1;
    expect_next("go_done_clr", SIG_DONE, 32'd0);
    expect_next("go_busy", SIG_BUSY, 32'd0);
    expect_next("go_level_kept", SIG_LEVEL, 32'd2);
    step();

    // Timeout: eight GEN_WAIT cycles without ack.
    start_setup = 1'b1;
    expect_next("restart_busy", SIG_BUSY, 32'd1);
    step();
    start_setup = 1'b1;
    expect_next("start_ignored_select", SIG_BUSY, 32'd1);
    step();
    confirm_and_load("tmo", 24, 99, 900);
    for (int i = 1; i <= 7; i++) begin
      expect_next("tmo_wait_req", SIG_REQ, 32'd1);
      expect_next("tmo_no_err", SIG_ERR, 32'd0);
      step();
    end
    expect_next("tmo_err", SIG_ERR, 32'd1);
    expect_next("tmo_req_drop", SIG_REQ, 32'd0);
    expect_next("tmo_busy", SIG_BUSY, 32'd1);
    step();
    btn_down = 1'b1;
    expect_next("tmo_err_pulse", SIG_ERR, 32'd0);
    expect_next("tmo_in_select", SIG_LEVEL, 32'd1);
    step();

    // Ack exactly in the timeout cycle: ack wins.
    confirm_and_load("med", 16, 40, 600);
    for (int i = 1; i <= 7; i++) begin
      expect_next("late_wait_req", SIG_REQ, 32'd1);
      step();
    end
    gen_ack = 1'b1;
    expect_next("late_ack_done", SIG_DONE, 32'd1);
    expect_next("late_ack_no_err", SIG_ERR, 32'd0);
    expect_next("late_ack_req", SIG_REQ, 32'd0);
    step();
    expect_next("late_ack_no_err2", SIG_ERR, 32'd0);
    step();

    // Start from READY, then abort during LD_MINES.
    start_setup = 1'b1;
    expect_next("ready_restart_done", SIG_DONE, 32'd0);
    expect_next("ready_restart_busy", SIG_BUSY, 32'd1);
    step();
    btn_down = 1'b1;
    expect_next("down_to_0", SIG_LEVEL, 32'd0);
    step();
    btn_confirm = 1'b1;
    expect_load("easy_size", 3'b001, 8);
    step();
    expect_load("easy_mines", 3'b010, 10);
    step();
    game_over = 1'b1;
    expect_next("abort_latch", SIG_LATCH, 32'd0);
    expect_next("abort_busy", SIG_BUSY, 32'd0);
    expect_next("abort_cfg", SIG_CFG, 32'd0);
    step();
    btn_up = 1'b1;
    expect_next("abort_idle_level", SIG_LEVEL, 32'd0);
    expect_next("abort_idle_busy", SIG_BUSY, 32'd0);
    step();

    // Asynchronous reset in GEN_WAIT.
    start_setup = 1'b1;
    step();
    confirm_and_load("easy", 8, 10, 300);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", 32'(gen_req), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_level", 32'(level_sel), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_next("post_rst_idle", SIG_BUSY, 32'd0);
    expect_next("post_rst_req", SIG_REQ, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
